// File: rtl/fetch_btb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_btb_stage_if                                     |
// | Description : Control, training, instruction-memory and IF/ID bundle |
// |               for the fetch stage. The slave side is the fetch       |
// |               stage; the master side is the surrounding pipeline.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface fetch_btb_stage_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    output imem_rdata,
    input  imem_addr,
    input  if_valid, if_pc, if_instr, if_pred_taken, if_pred_target
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    input  imem_rdata,
    output imem_addr,
    output if_valid, if_pc, if_instr, if_pred_taken, if_pred_target
  );
endinterface
`default_nettype wire

// File: rtl/fetch_btb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_btb_stage                                        |
// | Description : Instruction-fetch stage with PC ownership, IF/ID       |
// |               register and a direct-mapped BTB with 2-bit            |
// |               saturating direction counters.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_btb_stage #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              reset,
  fetch_btb_stage_if.slave  bus
);

  localparam int          IDX   = $clog2(BTB_ENTRIES);
  localparam int          TAGW  = XLEN - IDX - 2;
  localparam int          TGTW  = XLEN - 2;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  // BTB storage; targets are word addresses (low two bits implied zero)
  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [TAGW-1:0]        r_btb_tag [BTB_ENTRIES];
  logic [TGTW-1:0]        r_btb_tgt [BTB_ENTRIES];
  logic [1:0]             r_btb_ctr [BTB_ENTRIES];

  logic [XLEN-1:0] r_pc;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [31:0]     r_if_instr;
  logic            r_if_pred_taken;
  logic [XLEN-1:0] r_if_pred_target;

  logic [IDX-1:0]  w_lkp_idx;
  logic            w_lkp_hit;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  logic [IDX-1:0]  w_upd_idx;
  logic [TAGW-1:0] w_upd_tag;
  logic            w_upd_hit;

  // Low address bits of redirect/training inputs are ignored by design
  logic            w_unused_bits;

  assign w_lkp_idx     = r_pc[IDX+1:2];
  assign w_lkp_hit     = r_btb_valid[w_lkp_idx] && (r_btb_tag[w_lkp_idx] == r_pc[XLEN-1:IDX+2]);
  assign w_pred_taken  = w_lkp_hit && r_btb_ctr[w_lkp_idx][1];
  assign w_pred_target = {r_btb_tgt[w_lkp_idx], 2'b00};

  assign w_upd_idx     = bus.upd_pc[IDX+1:2];
  assign w_upd_tag     = bus.upd_pc[XLEN-1:IDX+2];
  assign w_upd_hit     = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);

  assign w_unused_bits = ^{bus.redirect_pc[1:0], bus.upd_pc[1:0], bus.upd_target[1:0]};

  assign bus.imem_addr      = r_pc;
  assign bus.if_valid       = r_if_valid;
  assign bus.if_pc          = r_if_pc;
  assign bus.if_instr       = r_if_instr;
  assign bus.if_pred_taken  = r_if_pred_taken;
  assign bus.if_pred_target = r_if_pred_target;

  // Next-PC selection: redirect beats stall, stall beats prediction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (!bus.stall) begin
      r_pc <= w_pred_taken ? w_pred_target : (r_pc + XLEN'(4));
    end
  end

  // IF/ID register: a redirect flushes the slot even while decode stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid       <= 1'b0;
      r_if_pc          <= '0;
      r_if_instr       <= C_NOP;
      r_if_pred_taken  <= 1'b0;
      r_if_pred_target <= '0;
    end else if (bus.redirect_valid) begin
      r_if_valid       <= 1'b0;
    end else if (!bus.stall) begin
      r_if_valid       <= 1'b1;
      r_if_pc          <= r_pc;
      r_if_instr       <= bus.imem_rdata;
      r_if_pred_taken  <= w_pred_taken;
      r_if_pred_target <= w_pred_taken ? w_pred_target : '0;
    end
  end

  // BTB training: hits adjust the counter, taken misses allocate weakly-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
        r_btb_ctr[i] <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      if (w_upd_hit) begin
        if (bus.upd_taken) begin
          r_btb_tgt[w_upd_idx] <= bus.upd_target[XLEN-1:2];
          if (r_btb_ctr[w_upd_idx] != 2'b11) begin
            r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] + 2'b01;
          end
        end else if (r_btb_ctr[w_upd_idx] != 2'b00) begin
          r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        r_btb_valid[w_upd_idx] <= 1'b1;
        r_btb_tag[w_upd_idx]   <= w_upd_tag;
        r_btb_tgt[w_upd_idx]   <= bus.upd_target[XLEN-1:2];
        r_btb_ctr[w_upd_idx]   <= 2'b10;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_btb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_btb_stage                                     |
// | Description : Randomised + directed scoreboard bench for the fetch   |
// |               stage against a behavioural fetch/BTB model.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fetch_btb_stage;

  localparam int NENT = 16;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
    logic [31:0] ptgt;
    logic [31:0] addr;
  } exp_t;

  // Model BTB slot: remembers the whole branch word address and target
  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  fetch_btb_stage_if #(.XLEN(32)) bus ();

  fetch_btb_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .BTB_ENTRIES(NENT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = instr_of(bus.imem_addr);

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  ent_t        m_btb [NENT];
  logic [31:0] m_pc;
  exp_t        m_if;

  task automatic model_step(input bit rst, input bit st, input bit rv, input logic [31:0] rpc,
                            input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                            input bit ut);
    int          li;
    int          ui;
    bit          hit;
    bit          pt;
    logic [31:0] ptgt;
    exp_t        e;
    if (rst) begin
      m_pc = 32'h0;
      m_if = '{v: 1'b0, pc: 32'h0, instr: 32'h0000_0013, pt: 1'b0, ptgt: 32'h0, addr: 32'h0};
      for (int i = 0; i < NENT; i++) m_btb[i] = '{v: 1'b0, pc: 32'h0, tgt: 32'h0, ctr: 1};
    end else begin
      li   = int'((m_pc >> 2) % NENT);
      hit  = m_btb[li].v && ((m_btb[li].pc >> 2) == (m_pc >> 2));
      pt   = hit && (m_btb[li].ctr >= 2);
      ptgt = pt ? m_btb[li].tgt : 32'h0;
      if (rv) begin
        m_if.v = 1'b0;
      end else if (!st) begin
        m_if.v     = 1'b1;
        m_if.pc    = m_pc;
        m_if.instr = instr_of(m_pc);
        m_if.pt    = pt;
        m_if.ptgt  = ptgt;
      end
      if (rv)       m_pc = rpc & ~32'h3;
      else if (!st) m_pc = pt ? ptgt : m_pc + 32'd4;
      if (uv) begin
        ui = int'((upc >> 2) % NENT);
        if (m_btb[ui].v && ((m_btb[ui].pc >> 2) == (upc >> 2))) begin
          if (ut) begin
            m_btb[ui].ctr = (m_btb[ui].ctr == 3) ? 3 : m_btb[ui].ctr + 1;
            m_btb[ui].tgt = utgt & ~32'h3;
          end else begin
            m_btb[ui].ctr = (m_btb[ui].ctr == 0) ? 0 : m_btb[ui].ctr - 1;
          end
        end else if (ut) begin
          m_btb[ui] = '{v: 1'b1, pc: upc & ~32'h3, tgt: utgt & ~32'h3, ctr: 2};
        end
      end
    end
    e      = m_if;
    e.addr = m_pc;
    q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input bit ut);
    @(negedge clk);
    reset              = rst;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_target     = utgt;
    bus.upd_taken      = ut;
    model_step(rst, st, rv, rpc, uv, upc, utgt, ut);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic redir(input logic [31:0] a, input bit st);
    step(0, st, 1, a, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    step(0, 0, 0, 32'h0, 1, pc, tgt, taken);
  endtask

  // Monitor: one expected snapshot per clock edge, checked just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.if_valid !== e.v || bus.if_pc !== e.pc || bus.if_instr !== e.instr ||
            bus.if_pred_taken !== e.pt || bus.if_pred_target !== e.ptgt ||
            bus.imem_addr !== e.addr) begin
          n_bad++;
          $display("FAIL snapshot t=%0t got v=%b pc=%h instr=%h pt=%b ptgt=%h addr=%h want v=%b pc=%h instr=%h pt=%b ptgt=%h addr=%h",
                   $time, bus.if_valid, bus.if_pc, bus.if_instr, bus.if_pred_taken,
                   bus.if_pred_target, bus.imem_addr, e.v, e.pc, e.instr, e.pt, e.ptgt, e.addr);
        end
      end
    end
  end

  initial begin
    bit          rst;
    bit          st;
    bit          rv;
    bit          uv;
    bit          ut;
    logic [31:0] rpc;
    logic [31:0] upc;
    logic [31:0] utgt;

    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;

    // Reset, free-run, stall at 0x10
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    run(4);
    hold(3);
    run(2);

    // Redirect to an unaligned address while stalled
    redir(32'h0000_0203, 1'b1);
    run(2);

    // Train 0x40 -> 0x80 taken, then fetch through it
    train(32'h40, 32'h80, 1'b1);
    redir(32'h40, 1'b0);
    run(3);

    // Weaken to 00, then saturate at 00
    train(32'h40, 32'h80, 1'b0);
    train(32'h40, 32'h80, 1'b0);
    redir(32'h40, 1'b0);
    run(2);
    train(32'h40, 32'h80, 1'b0);
    train(32'h40, 32'h80, 1'b0);
    redir(32'h40, 1'b0);
    run(2);

    // Aliasing entry replaces 0x40
    train(32'h40, 32'h80, 1'b1);
    train(32'h440, 32'h100, 1'b1);
    redir(32'h40, 1'b0);
    run(2);
    redir(32'h440, 1'b0);
    run(2);

    // Strengthen to 11 and saturate, fetch while training the same slot
    train(32'h440, 32'h104, 1'b1);
    train(32'h440, 32'h108, 1'b1);
    redir(32'h440, 1'b0);
    step(0, 0, 0, 32'h0, 1, 32'h440, 32'h200, 1'b0);
    run(2);

    // PC wrap
    redir(32'hFFFF_FFFC, 1'b0);
    run(3);

    // Reset overrides a concurrent redirect and training
    step(1, 1, 1, 32'h300, 1, 32'h0, 32'h40, 1);
    run(3);

    // Randomised phase over a small address window to provoke BTB hits
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 199) == 0);
      st   = ($urandom_range(0, 3) == 0);
      rv   = ($urandom_range(0, 7) == 0);
      rpc  = $urandom_range(0, 32'h7FF);
      uv   = ($urandom_range(0, 2) == 0);
      upc  = ($urandom_range(0, 1) == 0) ? ($urandom_range(0, 32'h7FF)) : ($urandom & 32'hFFFF_FFFF);
      utgt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h7FF);
      ut   = ($urandom_range(0, 2) != 0);
      step(rst, st, rv, rpc, uv, upc, utgt, ut);
    end

    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
